riscv_run_controller: RTL and testbench

Synthesizable run controller for the RISC-V pipelined processor: sequences the core's reset, runs it for a bounded number of cycles, and detects program completion through a store to a `tohost` address. It reports pass/fail/timeout, exit code, cycle count and retired-instruction count. It sits between the bench or board reset logic and the processor top, driving the core's `resetn`. It replaces hard-coded reset and run delays with a parametrised, restartable mechanism.

---
 rtl/riscv_run_controller_if.sv | 35 +++
 rtl/riscv_run_controller.sv | 105 ++++++++++
 tb/tb_riscv_run_controller.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_run_controller_if.sv
// Run-controller bus: run request and retire/store snoop from the core side,
// plus the core reset and run results from the controller.
//   master : drives start/retire_valid/store_*, observes results
//   slave  : the controller itself
interface riscv_run_controller_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic              start;
  logic              retire_valid;
  logic              store_valid;
  logic [XLEN-1:0]   store_addr;
  logic [XLEN-1:0]   store_data;
  logic              core_resetn;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [XLEN-2:0]   exit_code;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output start, retire_valid, store_valid, store_addr, store_data,
    input  core_resetn, busy, done, pass, fail, timeout, exit_code,
           cycle_count, retire_count
  );

  modport slave (
    input  start, retire_valid, store_valid, store_addr, store_data,
    output core_resetn, busy, done, pass, fail, timeout, exit_code,
           cycle_count, retire_count
  );
endinterface

// File: rtl/riscv_run_controller.sv
// Run controller for the pipelined RISC-V core: holds the core in reset for
// RESET_CYCLES after a start request, lets it run for at most MAX_CYCLES,
// and ends the run on an odd store to TOHOST_ADDR (1 = pass, else fail with
// exit code store_data[XLEN-1:1]) or on budget exhaustion (timeout).
//   clk, reset : clock and asynchronous active-high controller reset
//   bus        : slave side of riscv_run_controller_if (start, retire/store
//                snoop in; core_resetn, busy, done, pass/fail/timeout,
//                exit_code, cycle_count, retire_count out; all registered)
module riscv_run_controller #(
  parameter int              XLEN         = 32,
  parameter int              CNT_W        = 32,
  parameter int              RESET_CYCLES = 4,
  parameter int              MAX_CYCLES   = 1000,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_1000
) (
  input logic                    clk,
  input logic                    reset,
  riscv_run_controller_if.slave  bus
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_last;
  logic              completion;
  logic              budget_end;
  logic              start_ok;

  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    hold_last  = (hold_cnt == HOLD_W'(RESET_CYCLES - 1));
    completion = bus.store_valid && (bus.store_addr == TOHOST_ADDR) &&
                 bus.store_data[0];
    // cycle_count still holds the pre-increment value in the final budget cycle
    budget_end = (bus.cycle_count == CNT_W'(MAX_CYCLES - 1));
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RESET_HOLD;
          start_ok = 1'b1;
        end
      end
      RESET_HOLD: if (hold_last) state_d = RUN;
      RUN:        if (completion || budget_end) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt         <= '0;
      bus.core_resetn  <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.pass         <= 1'b0;
      bus.fail         <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.exit_code    <= '0;
      bus.cycle_count  <= '0;
      bus.retire_count <= '0;
    end else begin
      bus.core_resetn <= (state_d == RUN);
      bus.busy        <= (state_d == RESET_HOLD) || (state_d == RUN);
      bus.done        <= (state_d == DONE);
      if (start_ok) begin
        hold_cnt         <= '0;
        bus.pass         <= 1'b0;
        bus.fail         <= 1'b0;
        bus.timeout      <= 1'b0;
        bus.exit_code    <= '0;
        bus.cycle_count  <= '0;
        bus.retire_count <= '0;
      end else if (state_q == RESET_HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else if (state_q == RUN) begin
        bus.cycle_count <= bus.cycle_count + 1'b1;
        if (bus.retire_valid && (bus.retire_count != '1))
          bus.retire_count <= bus.retire_count + 1'b1;
        // Completion takes priority over a coincident budget expiry.
        if (completion) begin
          if (bus.store_data == XLEN'(1)) begin
            bus.pass <= 1'b1;
          end else begin
            bus.fail      <= 1'b1;
            bus.exit_code <= bus.store_data[XLEN-1:1];
          end
        end else if (budget_end) begin
          bus.timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_run_controller.sv
// Bench for riscv_run_controller: two instances (wide counters / 4-cycle
// reset / 50-cycle budget, and 4-bit counters / 1-cycle reset / 15-cycle
// budget) share one stimulus stream; each is tracked by a run-level model
// and compared on every falling edge, plus literal checks on instance A.
module tb_riscv_run_controller;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        retire = 1'b0;
  logic        sv    = 1'b0;
  logic [31:0] sa    = '0;
  logic [31:0] sd    = '0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  riscv_run_controller_if #(.XLEN(32), .CNT_W(32)) ifa ();
  riscv_run_controller_if #(.XLEN(32), .CNT_W(4))  ifb ();

  assign ifa.start = start;  assign ifa.retire_valid = retire;
  assign ifa.store_valid = sv; assign ifa.store_addr = sa; assign ifa.store_data = sd;
  assign ifb.start = start;  assign ifb.retire_valid = retire;
  assign ifb.store_valid = sv; assign ifb.store_addr = sa; assign ifb.store_data = sd;

  riscv_run_controller #(.XLEN(32), .CNT_W(32), .RESET_CYCLES(4), .MAX_CYCLES(50),
                         .TOHOST_ADDR(32'h0000_1000))
    dut_a (.clk(clk), .reset(rst), .bus(ifa));

  riscv_run_controller #(.XLEN(32), .CNT_W(4), .RESET_CYCLES(1), .MAX_CYCLES(15),
                         .TOHOST_ADDR(32'h0000_1000))
    dut_b (.clk(clk), .reset(rst), .bus(ifb));

  // Run-level model: remaining hold cycles, running flag, result and counts.
  typedef struct {
    int     hold;
    bit     run;
    bit     done;
    bit     pass_f;
    bit     fail_f;
    bit     to_f;
    longint cyc;
    longint ret;
    longint ext;
  } model_t;

  model_t ma = '{default: 0};
  model_t mb = '{default: 0};

  function automatic model_t step(model_t m, logic st, logic rv, logic v,
                                  logic [31:0] a, logic [31:0] d,
                                  int r_cycles, int max_cycles, int cw);
    model_t n = m;
    longint sat = (longint'(1) << cw) - 1;
    if (m.hold > 0) begin
      n.hold = m.hold - 1;
      if (n.hold == 0) n.run = 1'b1;
    end else if (m.run) begin
      n.cyc = m.cyc + 1;
      if (rv && m.ret < sat) n.ret = m.ret + 1;
      if (v && a == 32'h1000 && d[0]) begin
        n.run  = 1'b0;
        n.done = 1'b1;
        if (d == 32'd1) n.pass_f = 1'b1;
        else begin
          n.fail_f = 1'b1;
          n.ext    = longint'(d >> 1);
        end
      end else if (n.cyc == max_cycles) begin
        n.run  = 1'b0;
        n.done = 1'b1;
        n.to_f = 1'b1;
      end
    end else if (st) begin
      n      = '{default: 0};
      n.hold = r_cycles;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= step(ma, start, retire, sv, sa, sd, 4, 50, 32);
      mb <= step(mb, start, retire, sv, sa, sd, 1, 15, 4);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string p, input model_t m,
                           input logic busy, input logic rn, input logic dn,
                           input logic ps, input logic fl, input logic to,
                           input logic [63:0] ex, input logic [63:0] cy,
                           input logic [63:0] rt);
    chk({p, "busy"},        busy, 64'(m.hold > 0 || m.run));
    chk({p, "core_resetn"}, rn,   64'(m.run));
    chk({p, "done"},        dn,   64'(m.done));
    chk({p, "pass"},        ps,   64'(m.pass_f));
    chk({p, "fail"},        fl,   64'(m.fail_f));
    chk({p, "timeout"},     to,   64'(m.to_f));
    chk({p, "exit_code"},   ex,   m.ext);
    chk({p, "cycle_count"}, cy,   m.cyc);
    chk({p, "retire_count"}, rt,  m.ret);
  endtask

  always @(negedge clk) begin
    cmp_model("a_", ma, ifa.busy, ifa.core_resetn, ifa.done, ifa.pass, ifa.fail,
              ifa.timeout, 64'(ifa.exit_code), 64'(ifa.cycle_count), 64'(ifa.retire_count));
    cmp_model("b_", mb, ifb.busy, ifb.core_resetn, ifb.done, ifb.pass, ifb.fail,
              ifb.timeout, 64'(ifb.exit_code), 64'(ifb.cycle_count), 64'(ifb.retire_count));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a run on instance A and return just after core_resetn rises.
  task automatic start_run();
    int k;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_clears_done", 64'(ifa.done), 64'd0);
    chk("start_clears_cycle", 64'(ifa.cycle_count), 64'd0);
    k = 0;
    while (!ifa.core_resetn && k < 20) begin
      cyc();
      k++;
    end
    if (!ifa.core_resetn) chk("run_entry_bound", 64'(ifa.core_resetn), 64'd1);
  endtask

  initial begin
    int k;
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_core_resetn", 64'(ifa.core_resetn), 64'd0);
    chk("reset_busy", 64'(ifa.busy), 64'd0);
    cyc();

    // Reset sequencing: core_resetn low for 4 cycles after the start edge.
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("seq_busy", 64'(ifa.busy), 64'd1);
    chk("seq_rn_low0", 64'(ifa.core_resetn), 64'd0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("seq_rn_low", 64'(ifa.core_resetn), 64'd0);
    end
    cyc();
    chk("seq_rn_high", 64'(ifa.core_resetn), 64'd1);

    // Pass on the 20th RUN cycle with a retire every cycle.
    retire = 1'b1;
    repeat (19) cyc();
    sv = 1'b1; sa = 32'h1000; sd = 32'h1;
    cyc();
    sv = 1'b0; retire = 1'b0;
    chk("pass_flag", 64'(ifa.pass), 64'd1);
    chk("pass_done", 64'(ifa.done), 64'd1);
    chk("pass_cycles", 64'(ifa.cycle_count), 64'd20);
    chk("pass_retires", 64'(ifa.retire_count), 64'd20);
    chk("pass_rn", 64'(ifa.core_resetn), 64'd0);
    cyc();
    chk("done_sticky", 64'(ifa.done), 64'd1);

    // Fail with ignored even store, ignored start and wrong address first.
    start_run();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    sv = 1'b1; sa = 32'h1000; sd = 32'h6;
    cyc();
    chk("even_store_ignored", 64'(ifa.done), 64'd0);
    sa = 32'h1004; sd = 32'h1;
    cyc();
    chk("wrong_addr_ignored", 64'(ifa.done), 64'd0);
    sa = 32'h1000; sd = 32'h7;
    cyc();
    sv = 1'b0;
    chk("fail_flag", 64'(ifa.fail), 64'd1);
    chk("fail_pass", 64'(ifa.pass), 64'd0);
    chk("fail_exit", 64'(ifa.exit_code), 64'd3);
    chk("fail_cycles", 64'(ifa.cycle_count), 64'd5);

    // Timeout.
    start_run();
    k = 0;
    while (!ifa.done && k < 100) begin
      cyc();
      k++;
    end
    chk("to_flag", 64'(ifa.timeout), 64'd1);
    chk("to_cycles", 64'(ifa.cycle_count), 64'd50);
    chk("to_pass", 64'(ifa.pass), 64'd0);

    // Completion in the final budget cycle beats the timeout.
    start_run();
    repeat (49) cyc();
    sv = 1'b1; sa = 32'h1000; sd = 32'h1;
    cyc();
    sv = 1'b0;
    chk("tie_pass", 64'(ifa.pass), 64'd1);
    chk("tie_timeout", 64'(ifa.timeout), 64'd0);
    chk("tie_cycles", 64'(ifa.cycle_count), 64'd50);

    // Asynchronous reset mid-run.
    start_run();
    repeat (10) cyc();
    chk("mid_cycles", 64'(ifa.cycle_count), 64'd10);
    #2 rst = 1'b1;
    #1;
    chk("arst_rn", 64'(ifa.core_resetn), 64'd0);
    chk("arst_busy", 64'(ifa.busy), 64'd0);
    chk("arst_cycles", 64'(ifa.cycle_count), 64'd0);
    chk("arst_b_busy", 64'(ifb.busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic checked by the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      start  = ($urandom_range(0, 15) == 0);
      retire = $urandom_range(0, 1) == 1;
      sv     = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0, 1:    sa = 32'h1000;
        2:       sa = 32'h1004;
        default: sa = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       sd = 32'h1;
        1:       sd = $urandom;
        2:       sd = $urandom & 32'hFFFF_FFFE;
        default: sd = $urandom | 32'h1;
      endcase
      cyc();
    end
    rst = 1'b0; start = 1'b0; retire = 1'b0; sv = 1'b0;
    repeat (5) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
